hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_controller_if.sv | 39 +++
 rtl/hazard_controller_load_use_detect.sv | 20 ++
 rtl/hazard_controller.sv | 141 ++++++++++++++
 tb/tb_hazard_controller.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN (stall/flush performance counters).
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned DRAIN_W      = 2;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned PERF_W       = 32;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller bundle: ID/EX hazard inputs and pipeline-register controls.
interface hazard_controller_if;
    import hazard_pkg::*;

    logic [REG_W-1:0]  IF_ID_rs1;
    logic [REG_W-1:0]  IF_ID_rs2;
    logic              IF_ID_use_rs1;
    logic              IF_ID_use_rs2;
    logic [REG_W-1:0]  ID_EX_rd;
    logic              ID_EX_mem_read;
    logic              IF_ID_is_halt;
    logic              ex_redirect;
    logic              dmem_busy;

    logic              pc_write;
    logic              IF_ID_write;
    logic              IF_ID_flush;
    logic              ID_EX_flush;
    logic              halted;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_events;

    // Pipeline side: presents hazard information, consumes controls
    modport master (
        output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
        output ID_EX_rd, ID_EX_mem_read, IF_ID_is_halt, ex_redirect, dmem_busy,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, halted,
        input  stall_cycles, flush_events
    );

    // Controller side
    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
        input  ID_EX_rd, ID_EX_mem_read, IF_ID_is_halt, ex_redirect, dmem_busy,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, halted,
        output stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_controller_load_use_detect.sv
// Combinational load-use hazard detection between the ID and EX instructions.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             hazard_c
);

    // x0 is never a real dependency, so a load targeting it cannot stall
    always_comb begin
        hazard_c = ex_mem_read && (ex_rd != '0) &&
                   ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory freeze
// and halt draining. Controls are combinational from state and inputs.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN enables stall/flush counters.
module hazard_controller
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    hazard_controller_if.slave hz
);

    localparam logic [1:0] RUN    = 2'(ST_RUN);
    localparam logic [1:0] DRAIN  = 2'(ST_DRAIN);
    localparam logic [1:0] HALTED = 2'(ST_HALTED);

    logic [1:0]         state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               load_use_c;
    logic               stall_evt_c;
    logic               flush_evt_c;
    logic               pc_write_c;
    logic               if_id_write_c;
    logic               if_id_flush_c;
    logic               id_ex_flush_c;
    logic               halted_c;

    load_use_detect u_load_use (
        .rs1         (hz.IF_ID_rs1),
        .rs2         (hz.IF_ID_rs2),
        .use_rs1     (hz.IF_ID_use_rs1),
        .use_rs2     (hz.IF_ID_use_rs2),
        .ex_rd       (hz.ID_EX_rd),
        .ex_mem_read (hz.ID_EX_mem_read),
        .hazard_c    (load_use_c)
    );

    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next state and controls; reset forces the idle RUN controls
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        halted_c      = 1'b0;
        stall_evt_c   = 1'b0;
        flush_evt_c   = 1'b0;
        if (reset) begin
            case (state_q)
                RUN: begin
                    if (hz.dmem_busy) begin
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        stall_evt_c   = 1'b1;
                    end else if (hz.ex_redirect) begin
                        // ID holds a wrong-path instruction: its hazards are irrelevant
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        flush_evt_c   = 1'b1;
                    end else if (load_use_c) begin
                        // A stalled halt is re-detected once its operand arrives
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        id_ex_flush_c = 1'b1;
                        stall_evt_c   = 1'b1;
                    end else if (hz.IF_ID_is_halt) begin
                        state_d       = DRAIN;
                        drain_d       = DRAIN_W'(DRAIN_CYCLES);
                        pc_write_c    = 1'b0;
                        if_id_flush_c = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    if (hz.dmem_busy) begin
                        stall_evt_c = 1'b1;
                    end else begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        drain_d       = drain_q - DRAIN_W'(1);
                        if (drain_q == DRAIN_W'(1)) begin
                            state_d = HALTED;
                        end
                    end
                end
                HALTED: begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    halted_c      = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.IF_ID_write = if_id_write_c;
    assign hz.IF_ID_flush = if_id_flush_c;
    assign hz.ID_EX_flush = id_ex_flush_c;
    assign hz.halted      = halted_c;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;

    // Free-running performance counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt_c) stall_q <= stall_q + PERF_W'(1);
            if (flush_evt_c) flush_q <= flush_q + PERF_W'(1);
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
`else
    logic unused_evt_c;
    assign unused_evt_c    = stall_evt_c ^ flush_evt_c;
    assign hz.stall_cycles = '0;
    assign hz.flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (counter checks follow HAZARD_PERF_COUNTERS_EN).
module tb_hazard_controller;

    localparam logic [4:0] NORM   = 5'b11000; // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, halted}
    localparam logic [4:0] LU     = 5'b00010;
    localparam logic [4:0] RED    = 5'b11110;
    localparam logic [4:0] HDET   = 5'b01100;
    localparam logic [4:0] DRN    = 5'b00110;
    localparam logic [4:0] BUSY   = 5'b00000;
    localparam logic [4:0] HLT    = 5'b00001;
`ifdef HAZARD_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    hazard_controller_if hz ();

    hazard_controller dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue the expectation, check it mid-cycle
    task automatic step(input string tag, input logic rst_v,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2,
                        input logic [4:0] rd, input logic mr,
                        input logic hlt, input logic rdr, input logic bsy,
                        input logic [4:0] exp_ctrl, input logic inc_s, input logic inc_f);
        exp_t       e;
        logic [4:0] got;
        reset             = rst_v;
        hz.IF_ID_rs1      = rs1;
        hz.IF_ID_rs2      = rs2;
        hz.IF_ID_use_rs1  = u1;
        hz.IF_ID_use_rs2  = u2;
        hz.ID_EX_rd       = rd;
        hz.ID_EX_mem_read = mr;
        hz.IF_ID_is_halt  = hlt;
        hz.ex_redirect    = rdr;
        hz.dmem_busy      = bsy;
        e.ctrl  = exp_ctrl;
        e.stall = m_stall;
        e.flush = m_flush;
        sb_q.push_back(e);
        @(negedge clk);
        got = {hz.pc_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_flush, hz.halted};
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (got === e.ctrl) else begin
                bad++;
                $error("FAIL %s ctrl got=%b exp=%b", tag, got, e.ctrl);
            end
            total++;
            assert (hz.stall_cycles === e.stall) else begin
                bad++;
                $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, hz.stall_cycles, e.stall);
            end
            total++;
            assert (hz.flush_events === e.flush) else begin
                bad++;
                $error("FAIL %s flush_events got=%0d exp=%0d", tag, hz.flush_events, e.flush);
            end
        end
        if (!rst_v) begin
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else if (PERF) begin
            m_stall = m_stall + 32'(inc_s);
            m_flush = m_flush + 32'(inc_f);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b0;
        hz.IF_ID_rs1      = 5'd0;
        hz.IF_ID_rs2      = 5'd0;
        hz.IF_ID_use_rs1  = 1'b0;
        hz.IF_ID_use_rs2  = 1'b0;
        hz.ID_EX_rd       = 5'd0;
        hz.ID_EX_mem_read = 1'b0;
        hz.IF_ID_is_halt  = 1'b0;
        hz.ex_redirect    = 1'b0;
        hz.dmem_busy      = 1'b0;
        @(posedge clk);
        #1;
        //    tag            rst   rs1    rs2    u1    u2    rd     mr    hlt   rdr   bsy   exp   inc_s inc_f
        step("rst",         1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("idle",        1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("lu_rs1",      1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b1, 1'b0);
        step("after_lu",    1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("rd_zero",     1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("no_use",      1'b1, 5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("lu_rs2",      1'b1, 5'd0,  5'd7,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b1, 1'b0);
        step("no_memrd",    1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("redir_all",   1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, RED,  1'b0, 1'b1);
        step("post_redir",  1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("busy_lu",     1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, BUSY, 1'b1, 1'b0);
        step("busy_redir",  1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, BUSY, 1'b1, 1'b0);
        step("halt_lu",     1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, LU,   1'b1, 1'b0);
        step("halt",        1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, HDET, 1'b0, 1'b0);
        step("drain3",      1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, DRN,  1'b0, 1'b0);
        step("drain_busy1", 1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, BUSY, 1'b1, 1'b0);
        step("drain_busy2", 1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, BUSY, 1'b1, 1'b0);
        step("drain2",      1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, DRN,  1'b0, 1'b0);
        step("drain1",      1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, DRN,  1'b0, 1'b0);
        step("halted",      1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, HLT,  1'b0, 1'b0);
        step("halted_evts", 1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, HLT,  1'b0, 1'b0);
        step("rst_halted",  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("idle2",       1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("halt2",       1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, HDET, 1'b0, 1'b0);
        step("d3_b",        1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, DRN,  1'b0, 1'b0);
        step("rst_drain2",  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("post_rst",    1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        step("lu_again",    1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b1, 1'b0);
        step("final",       1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
